// File: rtl/alu_muldiv_sequencer_if.sv
// Request/response and shared-ALU signals for alu_muldiv_sequencer.
//   Start/Op/SrcA/SrcB          : operation request from the execute stage
//   Busy/Done/Result/DivByZero  : status and registered result
//   ALUControl/ALUOpA/ALUOpB    : operands and control driven into the shared ALU
//   ALUResult/ALUCarry          : combinational ALU response
interface alu_muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             DivByZero;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] ALUOpA;
    logic [WIDTH-1:0] ALUOpB;
    logic [WIDTH-1:0] ALUResult;
    logic             ALUCarry;

    // Sequencer side
    modport slave (
        input  Start, Op, SrcA, SrcB, ALUResult, ALUCarry,
        output Busy, Done, Result, DivByZero, ALUControl, ALUOpA, ALUOpB
    );

    // Pipeline / ALU side
    modport master (
        output Start, Op, SrcA, SrcB, ALUResult, ALUCarry,
        input  Busy, Done, Result, DivByZero, ALUControl, ALUOpA, ALUOpB
    );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MUL (low word), DIVU and REMU built on the shared single-cycle ALU.
// Each operation runs WIDTH add/subtract iterations through the ALU.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : request, status/result and shared-ALU port set
module alu_muldiv_sequencer #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [3:0]  ALU_ADD_CTRL = 4'b0000,
    parameter logic [3:0]  ALU_SUB_CTRL = 4'b0001
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_muldiv_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;     // P (MUL) or R (DIV)
    logic [WIDTH-1:0] r_m;       // M (MUL) or D (DIV)
    logic [WIDTH-1:0] r_q;       // multiplier Q (MUL) or quotient/dividend Q (DIV)
    logic             r_is_rem;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_dbz;

    logic [WIDTH-1:0] w_rs;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_mul_p_nxt;
    logic [WIDTH-1:0] w_div_r_nxt;
    logic [WIDTH-1:0] w_div_q_nxt;
    logic             w_last;
    logic [3:0]       w_alu_ctrl;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;

    // Per-iteration next values; the ALU closes the loop combinationally.
    assign w_rs        = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
    // R's MSB shifted out means the true shifted remainder is >= 2^WIDTH > D.
    assign w_div_ok    = bus.ALUCarry | r_acc[WIDTH-1];
    assign w_mul_p_nxt = r_q[0] ? bus.ALUResult : r_acc;
    assign w_div_r_nxt = w_div_ok ? bus.ALUResult : w_rs;
    assign w_div_q_nxt = {r_q[WIDTH-2:0], w_div_ok};
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    // Shared-ALU drive: neutral ADD of zeros outside the iterating states.
    always_comb begin
        w_alu_ctrl = ALU_ADD_CTRL;
        w_alu_a    = '0;
        w_alu_b    = '0;
        case (r_state)
            S_MUL: begin
                w_alu_a = r_acc;
                w_alu_b = r_m;
            end
            S_DIV: begin
                w_alu_ctrl = ALU_SUB_CTRL;
                w_alu_a    = w_rs;
                w_alu_b    = r_m;
            end
            default: ;
        endcase
    end

    assign bus.ALUControl = w_alu_ctrl;
    assign bus.ALUOpA     = w_alu_a;
    assign bus.ALUOpB     = w_alu_b;
    assign bus.Busy       = r_busy;
    assign bus.Done       = r_done;
    assign bus.Result     = r_result;
    assign bus.DivByZero  = r_dbz;

    // Sequencer FSM with registered status and result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_is_rem <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_is_rem <= (bus.Op == OP_REMU);
                        case (bus.Op)
                            OP_MUL: begin
                                r_acc   <= '0;
                                r_m     <= bus.SrcA;
                                r_q     <= bus.SrcB;
                                r_dbz   <= 1'b0;
                                r_state <= S_MUL;
                            end
                            OP_DIVU, OP_REMU: begin
                                if (bus.SrcB == '0) begin
                                    r_result <= (bus.Op == OP_DIVU) ? '1 : bus.SrcA;
                                    r_dbz    <= 1'b1;
                                    r_done   <= 1'b1;
                                    r_state  <= S_DONE;
                                end else begin
                                    r_acc   <= '0;
                                    r_q     <= bus.SrcA;
                                    r_m     <= bus.SrcB;
                                    r_dbz   <= 1'b0;
                                    r_state <= S_DIV;
                                end
                            end
                            default: begin
                                // Reserved op completes immediately with a zero result.
                                r_result <= '0;
                                r_dbz    <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_p_nxt;
                    r_m   <= r_m << 1;
                    r_q   <= r_q >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_mul_p_nxt;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_r_nxt;
                    r_q   <= w_div_q_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= r_is_rem ? w_div_r_nxt : w_div_q_nxt;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Scoreboard bench for alu_muldiv_sequencer with a behavioural ALU and reference model.
module tb_alu_muldiv_sequencer;

    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset_n;

    alu_muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_muldiv_sequencer #(
        .WIDTH       (WIDTH),
        .ALU_ADD_CTRL(4'b0000),
        .ALU_SUB_CTRL(4'b0001)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Behavioural single-cycle ALU: ADD, and SUB with C = (A >= B) unsigned.
    always_comb begin
        if (bus.ALUControl == 4'b0001) begin
            bus.ALUResult = bus.ALUOpA - bus.ALUOpB;
            bus.ALUCarry  = (bus.ALUOpA >= bus.ALUOpB);
        end else begin
            {bus.ALUCarry, bus.ALUResult} = {1'b0, bus.ALUOpA} + {1'b0, bus.ALUOpB};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] res;
        logic        dbz;
        int          done_cyc;
        int          busy_len;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from the arithmetic definition of each op.
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic dbz, output logic fast);
        dbz  = 1'b0;
        fast = 1'b0;
        case (op)
            2'b00: res = a * b;
            2'b01: begin
                if (b == 0) begin res = 32'hFFFF_FFFF; dbz = 1'b1; fast = 1'b1; end
                else res = a / b;
            end
            2'b10: begin
                if (b == 0) begin res = a; dbz = 1'b1; fast = 1'b1; end
                else res = a % b;
            end
            default: begin res = 32'h0; fast = 1'b1; end
        endcase
    endtask

    // Monitor: pops one expectation for every Done pulse.
    int   busy_run  = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.Busy) busy_run++;
            else busy_run = 0;
            if (bus.Done) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: got Done high on consecutive cycles expected one-cycle pulse");
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got Done with result %h expected no completion", bus.Result);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("result op%0d", e.op), bus.Result, e.res);
                    chk($sformatf("dbz op%0d", e.op), 32'(bus.DivByZero), 32'(e.dbz));
                    chk($sformatf("done_cycle op%0d", e.op), 32'(cyc), 32'(e.done_cyc));
                    chk($sformatf("busy_len op%0d", e.op), 32'(busy_run), 32'(e.busy_len));
                end
            end
            prev_done = bus.Done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.Busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.Busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got Busy=1 after %0d cycles expected Busy=0", n);
        end
    endtask

    // Drive one request at a negedge while idle; record expectation after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        fast;
        wait_idle();
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        e.op = op;
        model_op(op, a, b, e.res, e.dbz, fast);
        e.done_cyc = cyc + (fast ? 0 : WIDTH);
        e.busy_len = fast ? 1 : WIDTH + 1;
        sb.push_back(e);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset_n   = 1'b0;
        bus.Start = 1'b0;
        bus.Op    = 2'b00;
        bus.SrcA  = '0;
        bus.SrcB  = '0;

        #12;
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        chk("reset_done", 32'(bus.Done), 32'd0);
        chk("reset_result", bus.Result, 32'd0);
        chk("reset_dbz", 32'(bus.DivByZero), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        @(negedge clk);
        chk("idle_alu_a", bus.ALUOpA, 32'd0);
        chk("idle_alu_b", bus.ALUOpB, 32'd0);
        chk("idle_alu_ctrl", 32'(bus.ALUControl), 32'd0);

        // Directed cases
        issue(2'b00, 32'd7, 32'd6);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        issue(2'b01, 32'd100, 32'd7);
        issue(2'b10, 32'd100, 32'd7);
        issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
        issue(2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
        issue(2'b01, 32'd5, 32'd0);
        issue(2'b10, 32'd5, 32'd0);
        issue(2'b11, 32'd123, 32'd456);

        // Start re-pulsed mid-MUL must be ignored
        issue(2'b00, 32'd3, 32'd4);
        repeat (5) @(posedge clk);
        #1;
        bus.Start = 1'b1;
        bus.Op    = 2'b01;
        bus.SrcA  = 32'd99;
        bus.SrcB  = 32'd0;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("result_held", bus.Result, 32'd12);
        chk("busy_after_ignored_start", 32'(bus.Busy), 32'd0);

        // Reset mid-DIV aborts without Done
        issue(2'b01, 32'hDEAD_BEEF, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_done", 32'(bus.Done), 32'd0);
        chk("abort_result", bus.Result, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue(2'b01, 32'd9, 32'd3);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                3:       rb = ra + 32'($urandom_range(1, 5));
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
- Multi-cycle controller that performs RV32M-style MUL (low 32 bits), DIVU and REMU using only the existing single-cycle ALU.
- Each operation is sequenced as 32 add or subtract iterations on the ALU.
- Sits beside the execute stage. Drives a dedicated operand/control port set into the ALU; the pipeline's existing mux selects it while Busy is high.
- Reads back ALUResult and the carry flag.

Parameters:
WIDTH, 32, datapath width; the iteration count equals WIDTH.
ALU_ADD_CTRL, 4'b0000, ALUControl encoding for A+B.
ALU_SUB_CTRL, 4'b0001, ALUControl encoding for A-B. On SUB, ALU C=1 iff A>=B unsigned.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
Start  in  1  request; sampled only in IDLE
Op  in  2  00 MUL, 01 DIVU, 10 REMU, 11 reserved
SrcA  in  WIDTH  multiplicand / dividend
SrcB  in  WIDTH  multiplier / divisor
Busy  out  1  high in every non-IDLE state
Done  out  1  one-cycle completion pulse
Result  out  WIDTH  registered result, held until the next accepted Start
DivByZero  out  1  registered; valid with Done, held with Result
ALUControl  out  4  control to the shared ALU
ALUOpA  out  WIDTH  ALU operand A
ALUOpB  out  WIDTH  ALU operand B
ALUResult  in  WIDTH  ALU result (combinational from ALUOpA/ALUOpB/ALUControl)
ALUCarry  in  1  ALU C flag

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE; Busy=0, Done=0, Result=0, DivByZero=0.
  - Iteration counter and internal registers cleared.
  - Reset mid-operation aborts immediately; no Done is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE: Start=1 at the edge is accepted.
  - SrcA, SrcB and Op are latched; counter=0.
  - Op=00 -> MUL.
  - Op=01/10 with SrcB!=0 -> DIV.
  - Op=01/10 with SrcB==0 -> DONE. Result = 0xFFFFFFFF (DIVU) or SrcA (REMU); DivByZero=1.
  - Op=11 -> DONE with Result=0, DivByZero=0.
- On any accepted Start, DivByZero is updated at the same edge.
- Start while Busy is ignored (no queueing, no corruption of the op in flight).
- MUL: registers P=0, M=SrcA, Q=SrcB. Each cycle:
  - ALUOpA=P, ALUOpB=M, ALUControl=ALU_ADD_CTRL.
  - At the edge: if Q[0], P<=ALUResult. Then M<=M<<1, Q<=Q>>1, counter++.
  - Carry is ignored; the result wraps modulo 2^WIDTH.
- DIV (restoring): registers R=0, Q=SrcA, D=SrcB. Each cycle:
  - Rs={R[WIDTH-2:0],Q[WIDTH-1]}; ALUOpA=Rs, ALUOpB=D, ALUControl=ALU_SUB_CTRL.
  - ok = ALUCarry | R[WIDTH-1]. The pre-shift MSB covers the 33-bit overflow of Rs.
  - If ok: R<=ALUResult, Q<={Q[WIDTH-2:0],1}. Else: R<=Rs, Q<={Q[WIDTH-2:0],0}. Counter++.
- Exit from MUL/DIV: the edge completing iteration WIDTH (counter==WIDTH-1) moves to DONE.
  - Result is loaded at the same edge: P for MUL, Q for DIVU, R for REMU.
- DONE: Done=1 for exactly one cycle; next edge -> IDLE unconditionally.
- Latency: the accepting edge is edge 0.
  - MUL/DIV: Done is high in the cycle after edge WIDTH (32), i.e. a 33-cycle issue-to-Done latency. Next Start can be accepted at edge WIDTH+2.
  - Div-by-zero and Op=11: Done is high in the cycle after edge 0.
- ALU outputs in IDLE/DONE: ALUControl=ALU_ADD_CTRL, ALUOpA=0, ALUOpB=0.
- Result and DivByZero change only at edges that accept a Start or complete an operation.

Test Plan:
- Bench instantiates the team's alu wired to the ALU ports, clk 10 ns; reset_n low for 2 cycles, then released.
- MUL 7*6 -> Result=42. Done high exactly in the cycle after edge 32 from acceptance, for 1 cycle. Busy high for 33 cycles.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MUL 0x10000*0x10000 -> 0x00000000.
- DIVU 100/7 -> 14, REMU 100/7 -> 2. DIVU 0xFFFFFFFF/0x80000001 -> 1 and REMU -> 0x7FFFFFFE, which exercises the R[31] path. DivByZero=0 on all.
- DIVU 5/0 -> 0xFFFFFFFF with DivByZero=1; REMU 5/0 -> 5 with DivByZero=1. Done in the cycle after acceptance. Op=11 -> Result=0, DivByZero=0, same timing.
- Start re-pulsed with different operands at iteration 5 of MUL 3*4 -> ignored, Result=12. Result stays 12 through IDLE until the next Start.
- reset_n asserted mid-DIV at iteration 10 -> Busy=0, Done=0, Result=0 immediately. After release, DIVU 9/3 -> 3 with normal latency.
